// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with synchronous flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build with a registered in_ready_o.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 96,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              valid_q, valid_d;
  logic [1:0]        count_q, count_d;
  logic              accept, xfer_out;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;

  assign in_ready_o = ready_q;
`else
  // Single entry: a consuming downstream frees the slot in the same cycle.
  assign in_ready_o = !valid_q || out_ready_i;
`endif

  assign accept      = in_valid_i && in_ready_o;
  assign xfer_out    = valid_q && out_ready_i;
  assign out_valid_o = valid_q;
  assign data_o      = main_q;
  assign count_o     = count_q;

  // Next-state and register-enable decode; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = RESET_VAL;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            main_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (xfer_out && accept) begin
            main_d = in_data_i;
          end else if (xfer_out) begin
            state_d = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state_d = ST_SKID;
            skid_d  = in_data_i;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          if (xfer_out) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    valid_d = (state_d != ST_EMPTY);
    case (state_d)
      ST_FULL: count_d = 2'd1;
      ST_SKID: count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
`ifdef PIPE_STAGE_SKID_EN
    ready_d = (state_d != ST_SKID);
`endif
  end

  // State and payload registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      valid_q <= 1'b0;
      count_q <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= RESET_VAL;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= valid_d;
      count_q <= count_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      ready_q <= ready_d;
`endif
    end
  end

  // Registered status outputs must stay consistent with each other.
  a_count_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (count_o != 2'd0) == out_valid_o);
`ifdef PIPE_STAGE_SKID_EN
  a_ready_count: assert property (@(posedge clk_i) disable iff (rst_i)
    in_ready_o == (count_o != 2'd2));
`else
  a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
    count_o != 2'd2);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based occupancy model, directed cases, random traffic.
module tb_pipe_stage_reg;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] RV = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] data;
  logic [1:0]   count;

  int total = 0;
  int bad = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] mlast = RV;

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage may take a payload when it has room; single entry also counts a same-cycle drain.
  function automatic bit m_ready(input bit ordy);
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || ordy;
  endfunction

  // One clock cycle: drive at negedge, check in_ready, advance model at posedge, check outputs.
  task automatic step(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit ordy);
    bit acc;
    bit xo;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    chk("in_ready", W'(in_ready), W'(m_ready(ordy)));
    acc = iv && m_ready(ordy);
    xo  = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (r || f) begin
      mq.delete();
      mlast = RV;
    end else begin
      if (xo) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      if (mq.size() > 0) mlast = mq[0];
    end
    @(negedge clk);
    chk("out_valid", W'(out_valid), W'(mq.size() > 0));
    chk("data", data, mlast);
    chk("count", W'(count), W'(mq.size()));
  endtask

  initial begin
    @(negedge clk);

    // Reset held two cycles, then stream 1,2,3.
    step(1, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);
    chk("lit_rst_valid", W'(out_valid), W'(0));
    chk("lit_rst_data", data, RV);
    chk("lit_rst_count", W'(count), W'(0));
    step(0, 0, 1, 32'h1, 1);
    chk("lit_s1", data, 32'h1);
    step(0, 0, 1, 32'h2, 1);
    chk("lit_s2", data, 32'h2);
    step(0, 0, 1, 32'h3, 1);
    chk("lit_s3", data, 32'h3);
    chk("lit_s3_valid", W'(out_valid), W'(1));
    step(0, 0, 0, '0, 1);
    chk("lit_drain_valid", W'(out_valid), W'(0));
    chk("lit_drain_hold", data, 32'h3);

    // Downstream stall with FULL holding 0xA and 0xB offered.
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    if (SKID) begin
      chk("lit_stall_count", W'(count), W'(2));
      chk("lit_stall_ready", W'(in_ready), W'(0));
    end else begin
      chk("lit_stall_count", W'(count), W'(1));
    end
    chk("lit_stall_head", data, 32'hA);
    step(0, 0, 0, '0, 1);
    if (SKID) chk("lit_unstall_b", data, 32'hB);
    else      chk("lit_unstall_empty", W'(out_valid), W'(0));
    step(0, 0, 0, '0, 1);
    chk("lit_unstall_done", W'(count), W'(0));

    // Flush while full (SKID in the skid build) with 0xC offered.
    step(0, 0, 1, 32'h5, 0);
    step(0, 0, 1, 32'h6, 0);
    step(0, 1, 1, 32'hC, 0);
    chk("lit_flush_valid", W'(out_valid), W'(0));
    chk("lit_flush_count", W'(count), W'(0));
    chk("lit_flush_data", data, RV);
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
    chk("lit_flush_noc", W'(out_valid), W'(0));

    // Reset and flush together, then flush alone while empty.
    step(0, 0, 1, 32'h7, 0);
    step(1, 1, 1, 32'h8, 0);
    chk("lit_rf_valid", W'(out_valid), W'(0));
    chk("lit_rf_data", data, RV);
    chk("lit_rf_count", W'(count), W'(0));
    step(0, 1, 0, '0, 0);
    chk("lit_fe_count", W'(count), W'(0));
    #1;
    chk("lit_fe_ready", W'(in_ready), W'(1));

    // Random valid/ready with occasional flush and rare reset.
    for (int i = 0; i < 10000; i++) begin
      bit r;
      bit f;
      bit iv;
      bit ordy;
      r    = ($urandom_range(0, 999) == 0);
      f    = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((i / 1000) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(r, f, iv, W'($urandom), ordy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
